// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with data-bus FSM, load formatting and the MEM/WB register.
// Define MISALIGN_TRAP_EN to add misalign_o and suppress misaligned H/W bus accesses.
module mem_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_4_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  funct3_i,
    input  logic        wb_sel1_i,
    input  logic        wb_sel2_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_we_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] pc_4_o,
    output logic [31:0] alu_o,
    output logic [31:0] mem_o,
    output logic        wb_sel1_o,
    output logic        wb_sel2_o,
    output logic [4:0]  rd_o,
    output logic        reg_we_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        bus_err_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_4;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        sel1;
        logic        sel2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        bus_err;
    } memwb_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    memwb_t           wb_q, wb_d;

    logic        mem_op, is_byte, is_half, misalign, wd_expire;
    logic        complete, bus_err;
    logic [1:0]  off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_fmt, mem_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign mem_op  = mem_rd_i | mem_wr_i;
    assign off     = alu_i[1:0];
    assign is_byte = (funct3_i[1:0] == 2'b00);
    assign is_half = (funct3_i[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign misalign = valid_i & mem_op &
                      ((is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign wd_expire = (TIMEOUT_CYC != 0) && (state_q == S_WAIT) && !dmem_rvalid_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    wait_cnt_q <= '0;
        else if (state_q != S_WAIT)  wait_cnt_q <= '0;
        else                         wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end

    always_comb begin
        // NOTE: default first, so no path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i && mem_op && !misalign) state_d = S_REQ;
            S_REQ:   if (dmem_gnt_i) state_d = (mem_wr_i || dmem_rvalid_i) ? S_IDLE : S_WAIT;
            S_WAIT:  if (dmem_rvalid_i || wd_expire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        complete   = 1'b0;
        bus_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (mem_op && !misalign) stall_o  = 1'b1;
                    else                     complete = 1'b1;
                end
            end
            S_REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i && (mem_wr_i || dmem_rvalid_i)) complete = 1'b1;
                else                                           stall_o  = 1'b1;
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    complete = 1'b1;
                end else if (wd_expire) begin
                    complete = 1'b1;
                    bus_err  = 1'b1;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: ;
        endcase
        // Reset releases upstream and the bus in the same cycle, not at the next edge.
        if (!rst) begin
            stall_o    = 1'b0;
            dmem_req_o = 1'b0;
        end
    end

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = store_data_i;
        if (is_byte) begin
            lane_be    = 4'b0001 << off;
            lane_wdata = {4{store_data_i[7:0]}};
        end else if (is_half) begin
            lane_be    = off[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{store_data_i[15:0]}};
        end
    end

    assign dmem_we_o    = dmem_req_o & mem_wr_i;
    assign dmem_addr_o  = dmem_req_o ? {alu_i[31:2], 2'b00} : 32'h0;
    assign dmem_be_o    = dmem_req_o ? lane_be : 4'b0000;
    assign dmem_wdata_o = dmem_we_o ? lane_wdata : 32'h0;

    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (off)
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            2'd3:    ld_byte = dmem_rdata_i[31:24];
            default: ld_byte = dmem_rdata_i[7:0];
        endcase
        ld_half = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (funct3_i)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = dmem_rdata_i;
        endcase
    end

    // Load data only exists on a real bus completion; aborts and traps write zero.
    assign mem_d = (complete && mem_rd_i && (state_q != S_IDLE) && !bus_err) ? load_fmt : 32'h0;

    always_comb begin
        wb_d = '0;
        if (complete) begin
            wb_d.valid   = 1'b1;
            wb_d.pc_4    = pc_4_i;
            wb_d.alu     = alu_i;
            wb_d.mem     = mem_d;
            wb_d.sel1    = wb_sel1_i;
            wb_d.sel2    = wb_sel2_i;
            wb_d.rd      = rd_i;
            wb_d.reg_we  = reg_we_i & ~bus_err & ~misalign;
            wb_d.bus_err = bus_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wb_q <= '0;
        else      wb_q <= wb_d;
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= complete & misalign;
    end
    assign misalign_o = misalign_q;
`endif

    assign wb_valid_o = wb_q.valid;
    assign pc_4_o     = wb_q.pc_4;
    assign alu_o      = wb_q.alu;
    assign mem_o      = wb_q.mem;
    assign wb_sel1_o  = wb_q.sel1;
    assign wb_sel2_o  = wb_q.sel2;
    assign rd_o       = wb_q.rd;
    assign reg_we_o   = wb_q.reg_we;
    assign bus_err_o  = wb_q.bus_err;

endmodule
